// File: rtl/timer_arbiter_if.sv
// Request/duration inputs and timer-control outputs shared between the
// mode FSMs, the timer arbiter and the countdown timer.
interface timer_arbiter_if #(
    parameter int N_REQ   = 3,
    parameter int OWNER_W = 2
);
    logic [N_REQ-1:0]   i_req;
    logic [4*N_REQ-1:0] i_sec;
    logic [N_REQ-1:0]   i_cancel;
    logic               i_pause;
    logic               i_timeout;
    logic               o_start_timer;
    logic               o_en;
    logic [3:0]         o_sw;
    logic [N_REQ-1:0]   o_grant;
    logic [N_REQ-1:0]   o_done;
    logic [OWNER_W-1:0] o_owner;
    logic               o_busy;

    modport slave (
        input  i_req, i_sec, i_cancel, i_pause, i_timeout,
        output o_start_timer, o_en, o_sw, o_grant, o_done, o_owner, o_busy
    );

    modport master (
        output i_req, i_sec, i_cancel, i_pause, i_timeout,
        input  o_start_timer, o_en, o_sw, o_grant, o_done, o_owner, o_busy
    );
endinterface

// File: rtl/timer_arbiter.sv
// Shares one countdown timer between N_REQ requesters (IDLE/LOAD/RUN/DONE).
// Define TIMER_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module timer_arbiter #(
    parameter int N_REQ   = 3,
    parameter int OWNER_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    timer_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state;
    logic [OWNER_W-1:0] win_idx;
    logic [3:0]         win_sec;
    logic               found;
    int                 cand;

`ifdef TIMER_ARB_RR_EN
    logic [OWNER_W-1:0] rr_ptr;

    function automatic logic [OWNER_W-1:0] after(input logic [OWNER_W-1:0] idx);
        if (int'(idx) == N_REQ - 1) return '0;
        return idx + 1'b1;
    endfunction
`endif

    function automatic logic [N_REQ-1:0] onehot(input logic [OWNER_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    // Winner search; round-robin rotates the starting index past the last owner
    always_comb begin
        win_idx = '0;
        win_sec = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef TIMER_ARB_RR_EN
            cand = (int'(rr_ptr) + i) % N_REQ;
`else
            cand = i;
`endif
            if (!found && bus.i_req[cand]) begin
                found   = 1'b1;
                win_idx = OWNER_W'(cand);
                win_sec = bus.i_sec[4*cand +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            bus.o_start_timer <= 1'b0;
            bus.o_en          <= 1'b0;
            bus.o_sw          <= '0;
            bus.o_grant       <= '0;
            bus.o_done        <= '0;
            bus.o_owner       <= '0;
            bus.o_busy        <= 1'b0;
`ifdef TIMER_ARB_RR_EN
            rr_ptr            <= '0;
`endif
        end else begin
            bus.o_start_timer <= 1'b0;
            bus.o_done        <= '0;
            bus.o_en          <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.o_owner <= win_idx;
                        bus.o_sw    <= win_sec;
                        bus.o_busy  <= 1'b1;
                        // A zero duration would never time out, so skip the timer
                        if (win_sec == 4'd0) begin
                            state      <= DONE;
                            bus.o_done <= onehot(win_idx);
`ifdef TIMER_ARB_RR_EN
                            rr_ptr     <= after(win_idx);
`endif
                        end else begin
                            state             <= LOAD;
                            bus.o_start_timer <= 1'b1;
                            bus.o_grant       <= onehot(win_idx);
                        end
                    end
                end
                LOAD: begin
                    state    <= RUN;
                    bus.o_en <= !bus.i_pause;
                end
                RUN: begin
                    if (bus.i_timeout) begin
                        state       <= DONE;
                        bus.o_grant <= '0;
                        bus.o_done  <= onehot(bus.o_owner);
`ifdef TIMER_ARB_RR_EN
                        rr_ptr      <= after(bus.o_owner);
`endif
                    end else if (|(bus.i_cancel & onehot(bus.o_owner))) begin
                        state       <= IDLE;
                        bus.o_grant <= '0;
                        bus.o_busy  <= 1'b0;
`ifdef TIMER_ARB_RR_EN
                        rr_ptr      <= after(bus.o_owner);
`endif
                    end else begin
                        bus.o_en <= !bus.i_pause;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: behavioural countdown timer (CLK_FREQ=4), directed
// scenarios and a randomized run against a transaction-level reference model.
module tb_timer_arbiter;
    localparam int N  = 3;
    localparam int OW = 2;
    localparam int CF = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    timer_arbiter_if #(.N_REQ(N), .OWNER_W(OW)) bus ();
    timer_arbiter #(.N_REQ(N), .OWNER_W(OW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Countdown timer: sec*CF enabled ticks, terminal pulse on the 1->0 step
    int   t_ticks;
    logic tmo;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_ticks <= 0;
            tmo     <= 1'b0;
        end else begin
            tmo <= 1'b0;
            if (bus.o_start_timer) t_ticks <= int'(bus.o_sw) * CF;
            else if (bus.o_en && t_ticks > 0) begin
                t_ticks <= t_ticks - 1;
                if (t_ticks == 1) tmo <= 1'b1;
            end
        end
    end
    assign bus.i_timeout = tmo;

    // Reference model: phase 0 free, 1 loading, 2 counting, 3 completing
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return 0;
    endfunction
    function automatic int nxt(input int w);
`ifdef TIMER_ARB_RR_EN
        return (w + 1) % N;
`else
        return 0 * w;
`endif
    endfunction
    function automatic int sec_of(input logic [4*N-1:0] s, input int w);
        return int'(s[4*w +: 4]);
    endfunction

    int   m_ph, m_own, m_sec, m_ptr;
    logic m_en;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_own <= 0; m_sec <= 0; m_ptr <= 0; m_en <= 1'b0;
        end else begin
            m_en <= 1'b0;
            case (m_ph)
                0: if (bus.i_req != '0) begin
                    m_own <= pick(bus.i_req, m_ptr);
                    m_sec <= sec_of(bus.i_sec, pick(bus.i_req, m_ptr));
                    if (sec_of(bus.i_sec, pick(bus.i_req, m_ptr)) == 0) begin
                        m_ph  <= 3;
                        m_ptr <= nxt(pick(bus.i_req, m_ptr));
                    end else m_ph <= 1;
                end
                1: begin m_ph <= 2; m_en <= !bus.i_pause; end
                2: if (bus.i_timeout) begin
                    m_ph <= 3; m_ptr <= nxt(m_own);
                end else if (bus.i_cancel[m_own]) begin
                    m_ph <= 0; m_ptr <= nxt(m_own);
                end else m_en <= !bus.i_pause;
                default: m_ph <= 0;
            endcase
        end
    end

    logic [N-1:0] exp_grant, exp_done;
    always_comb begin
        exp_grant = '0;
        exp_done  = '0;
        if (m_ph == 1 || m_ph == 2) exp_grant = N'(1) << m_own;
        if (m_ph == 3) exp_done = N'(1) << m_own;
    end

    task automatic set_in(input logic [N-1:0] req, input logic [4*N-1:0] sec,
                          input logic [N-1:0] cancel, input logic pause);
        bus.i_req    = req;
        bus.i_sec    = sec;
        bus.i_cancel = cancel;
        bus.i_pause  = pause;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in('0, 12'h555, '0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_start_timer, bus.o_en, bus.o_grant, bus.o_done, bus.o_owner, bus.o_sw, bus.o_busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {bus.o_start_timer, bus.o_en, bus.o_grant, bus.o_done, bus.o_owner, bus.o_sw, bus.o_busy});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_grant !== '0) begin
            failures++;
            $display("FAIL reset_idle busy=%b grant=%b want 0/000", bus.o_busy, bus.o_grant);
        end
    endtask

    task automatic test_basic();
        int en_cnt = 0;
        bit got = 0;
        set_in(3'b001, {4'd7, 4'd9, 4'd3}, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.o_start_timer !== 1'b1 || bus.o_grant !== 3'b001) begin
            failures++;
            $display("FAIL basic_load start=%b grant=%b want 1/001", bus.o_start_timer, bus.o_grant);
        end
        checks++;
        if (bus.o_sw !== 4'd3 || bus.o_owner !== 2'd0) begin
            failures++;
            $display("FAIL basic_latch sw=%0d owner=%0d want 3/0", bus.o_sw, bus.o_owner);
        end
        bus.i_req = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.o_en) en_cnt++;
            if (bus.i_timeout) begin got = 1; break; end
        end
        checks++;
        if (!got || en_cnt != 13) begin
            failures++;
            $display("FAIL basic_en_cycles got=%0d timeout_seen=%0d want 13/1", en_cnt, got);
        end
        @(negedge clk);
        checks++;
        if (bus.o_done !== 3'b001 || bus.o_grant !== '0 || bus.o_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_done done=%b grant=%b busy=%b want 001/000/1", bus.o_done, bus.o_grant, bus.o_busy);
        end
        @(negedge clk);
        checks++;
        if (bus.o_done !== '0 || bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle done=%b busy=%b want 000/0", bus.o_done, bus.o_busy);
        end
    endtask

    task automatic test_arbitration();
        logic [N-1:0] g[2];
        int at[2];
        int n = 0;
        logic [N-1:0] want1;
`ifdef TIMER_ARB_RR_EN
        want1 = 3'b010;
`else
        want1 = 3'b001;
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_in(3'b011, {4'd0, 4'd1, 4'd1}, '0, 1'b0);
        for (int c = 0; c < 100 && n < 2; c++) begin
            @(negedge clk);
            if (bus.o_start_timer) begin
                g[n] = bus.o_grant; at[n] = c; n++;
            end
        end
        bus.i_req = '0;
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL arb_two_grants got=%0d want 2", n);
        end else begin
            checks++;
            if (g[0] !== 3'b001 || g[1] !== want1) begin
                failures++;
                $display("FAIL arb_order got=%b,%b want 001,%b", g[0], g[1], want1);
            end
            checks++;
            if (at[1] - at[0] != 8) begin
                failures++;
                $display("FAIL arb_spacing got=%0d want 8", at[1] - at[0]);
            end
        end
        for (int c = 0; c < 50 && bus.o_busy; c++) @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL arb_release busy=%b want 0", bus.o_busy);
        end
    endtask

    task automatic test_zero();
        bit started = 0;
        set_in(3'b100, {4'd0, 4'd5, 4'd5}, '0, 1'b0);
        @(negedge clk);
        bus.i_req = '0;
        started |= bus.o_start_timer;
        checks++;
        if (bus.o_done !== 3'b100 || bus.o_grant !== '0 || bus.o_busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_done done=%b grant=%b busy=%b want 100/000/1", bus.o_done, bus.o_grant, bus.o_busy);
        end
        @(negedge clk);
        started |= bus.o_start_timer;
        checks++;
        if (started || bus.o_done !== '0 || bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_after start_seen=%0d done=%b busy=%b want 0/000/0", started, bus.o_done, bus.o_busy);
        end
    endtask

    task automatic test_pause();
        int t = 0;
        bit got = 0;
        set_in(3'b001, {4'd1, 4'd1, 4'd2}, '0, 1'b0);
        @(negedge clk);
        bus.i_req = '0;
        checks++;
        if (bus.o_start_timer !== 1'b1) begin
            failures++;
            $display("FAIL pause_start got=%b want 1", bus.o_start_timer);
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            t++;
            if (bus.i_timeout) begin got = 1; break; end
            if (t >= 4 && t <= 23) begin
                checks++;
                if (bus.o_en !== 1'b0) begin
                    failures++;
                    $display("FAIL pause_en t=%0d got=%b want 0", t, bus.o_en);
                end
            end
            bus.i_pause = (t >= 3 && t <= 22);
        end
        bus.i_pause = 1'b0;
        checks++;
        if (!got || t != 4 * 2 + 1 + 20) begin
            failures++;
            $display("FAIL pause_delay got=%0d want %0d", t, 4 * 2 + 1 + 20);
        end
        @(negedge clk);
        checks++;
        if (bus.o_done !== 3'b001) begin
            failures++;
            $display("FAIL pause_done got=%b want 001", bus.o_done);
        end
        @(negedge clk);
    endtask

    task automatic test_cancel();
        bit spurious = 0;
        bit got = 0;
        bit early = 0;
        // owner cancel
        set_in(3'b010, {4'd1, 4'd5, 4'd1}, '0, 1'b0);
        @(negedge clk);
        bus.i_req = '0;
        @(negedge clk);
        bus.i_cancel = 3'b010;
        @(negedge clk);
        bus.i_cancel = '0;
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_grant !== '0 || bus.o_done !== '0) begin
            failures++;
            $display("FAIL cancel_owner busy=%b grant=%b done=%b want 0/000/000", bus.o_busy, bus.o_grant, bus.o_done);
        end
        repeat (30) begin
            @(negedge clk);
            if (bus.o_done !== '0 || bus.o_start_timer !== 1'b0) spurious = 1;
        end
        checks++;
        if (spurious) begin
            failures++;
            $display("FAIL cancel_quiet got=1 want 0");
        end
        // non-owner cancel
        set_in(3'b001, {4'd1, 4'd1, 4'd1}, '0, 1'b0);
        @(negedge clk);
        bus.i_req = '0;
        @(negedge clk);
        bus.i_cancel = 3'b110;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.o_done !== '0) begin got = 1; break; end
            if (!bus.o_busy) early = 1;
        end
        bus.i_cancel = '0;
        checks++;
        if (!got || early || bus.o_done !== 3'b001) begin
            failures++;
            $display("FAIL cancel_nonowner done=%b seen=%0d dropped=%0d want 001/1/0", bus.o_done, got, early);
        end
        @(negedge clk);
        // cancel coincident with timeout
        got = 0;
        set_in(3'b001, {4'd1, 4'd1, 4'd1}, '0, 1'b0);
        @(negedge clk);
        bus.i_req = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.i_timeout) begin got = 1; break; end
        end
        bus.i_cancel = 3'b001;
        @(negedge clk);
        bus.i_cancel = '0;
        checks++;
        if (!got || bus.o_done !== 3'b001) begin
            failures++;
            $display("FAIL cancel_vs_timeout done=%b seen=%0d want 001/1", bus.o_done, got);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        set_in(3'b001, {4'd1, 4'd1, 4'd4}, '0, 1'b0);
        @(negedge clk);
        bus.i_req = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_en !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_running busy=%b en=%b want 1/1", bus.o_busy, bus.o_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_start_timer, bus.o_en, bus.o_grant, bus.o_done, bus.o_owner, bus.o_sw, bus.o_busy} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%h want 0", {bus.o_start_timer, bus.o_en, bus.o_grant, bus.o_done, bus.o_owner, bus.o_sw, bus.o_busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(3'b001, {4'd1, 4'd1, 4'd1}, '0, 1'b0);
        @(negedge clk);
        bus.i_req = '0;
        checks++;
        if (bus.o_start_timer !== 1'b1 || bus.o_grant !== 3'b001) begin
            failures++;
            $display("FAIL rstmid_restart start=%b grant=%b want 1/001", bus.o_start_timer, bus.o_grant);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.o_done !== '0) begin got = 1; break; end
        end
        checks++;
        if (!got || bus.o_done !== 3'b001) begin
            failures++;
            $display("FAIL rstmid_done got=%b seen=%0d want 001/1", bus.o_done, got);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if (bus.o_start_timer !== (m_ph == 1)) begin
                failures++;
                $display("FAIL rnd_start cyc=%0d got=%b want=%b", c, bus.o_start_timer, (m_ph == 1));
            end
            checks++;
            if (bus.o_en !== m_en) begin
                failures++;
                $display("FAIL rnd_en cyc=%0d got=%b want=%b", c, bus.o_en, m_en);
            end
            checks++;
            if (bus.o_grant !== exp_grant) begin
                failures++;
                $display("FAIL rnd_grant cyc=%0d got=%b want=%b", c, bus.o_grant, exp_grant);
            end
            checks++;
            if (bus.o_done !== exp_done) begin
                failures++;
                $display("FAIL rnd_done cyc=%0d got=%b want=%b", c, bus.o_done, exp_done);
            end
            checks++;
            if (bus.o_busy !== (m_ph != 0)) begin
                failures++;
                $display("FAIL rnd_busy cyc=%0d got=%b want=%b", c, bus.o_busy, (m_ph != 0));
            end
            checks++;
            if (bus.o_owner !== OW'(m_own) || bus.o_sw !== 4'(m_sec)) begin
                failures++;
                $display("FAIL rnd_latch cyc=%0d owner=%0d sw=%0d want %0d/%0d", c, bus.o_owner, bus.o_sw, m_own, m_sec);
            end
            bus.i_req    = N'($urandom & $urandom);
            for (int r = 0; r < N; r++) bus.i_sec[4*r +: 4] = 4'($urandom_range(0, 3));
            bus.i_cancel = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            bus.i_pause  = ($urandom_range(0, 3) == 0);
        end
        set_in('0, '0, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arbitration();
        test_zero();
        test_pause();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
